inv_round_key_seq: RTL and testbench
====================================

// Module: inv_round_key_seq
// PURPOSE
//  Sequential AES-256 inverse key-schedule walker for the decryption datapath.
//  Loads the last two round keys (rk13||rk14 = words w[52..59]) and emits
//  round keys rk14, rk13, ..., rk0 one per handshake beat, in decryption order.
//  Each step regenerates four earlier words in parallel:
//  w[i-8] = w[i] ^ T(w[i-1]), using one SubWord (four rom_sbox lookups).
// PARAMETERS
//  word_w_p      32   key-word width; only 32 is supported
//  num_rounds_p  14   AES-256 round count; only 14 is supported
// PORTS
//  clk_i      in   1    clock, all state updates on rising edge
//  reset_n_i  in   1    asynchronous active-low reset
//  key_v_i    in   1    key_i valid
//  key_ready_o out 1    block idle and accepts a key
//  key_i      in   256  {w52,...,w59}; w52 in [255:224], w59 in [31:0]
//  v_o        out  1    rk_o / round_o valid
//  ready_i    in   1    consumer accepts current round key
//  rk_o       out  128  round key; first word in [127:96]
//  round_o    out  4    index n of rk_o (14 down to 0)
//  last_o     out  1    v_o & (round_o==0)
// BEHAVIOUR
//  - Byte order: byte 0 of a word is in [31:24].
//    RotWord{b0,b1,b2,b3}={b1,b2,b3,b0}. Rcon occupies the top byte.
//  - State: FSM IDLE/EMIT, window W[0..7] = w[4m..4m+7], 4-bit counter n.
//  - Reset (async, immediate): IDLE, key_ready_o=1, v_o=0, rk_o=0, round_o=0,
//    last_o=0, W=0. Any walk in progress is abandoned and nothing more is emitted.
//  - IDLE: key_ready_o=1, v_o=0. On key_v_i: W <= key_i, n <= 14, go to EMIT.
//    v_o is first high the next cycle (load-to-first-valid latency = 1).
//  - EMIT: key_ready_o=0; key_v_i is ignored. rk_o = W[4..7] when n=14,
//    otherwise W[0..3]. v_o=1.
//  - Hold rule: rk_o and round_o hold stable while v_o & !ready_i.
//  - Beat on v_o & ready_i:
//    n=14: n <= 13, W unchanged.
//    1<=n<=13 (m=n): W <= {X0,X1,X2,X3,W[0],W[1],W[2],W[3]}, n <= n-1.
//    n=0: go to IDLE, v_o <= 0, key_ready_o <= 1.
//  - New words (all combinational from registered W, no chaining):
//    X0 = W[4] ^ T(W[3]); X1 = W[5]^W[4]; X2 = W[6]^W[5]; X3 = W[7]^W[6].
//    T for m odd: SubWord(RotWord(W[3])) ^ {Rcon[(m+1)/2],24'h0}.
//    T for m even: SubWord(W[3]).
//  - Rcon[1..7] = 01,02,04,08,10,20,40. The n=13 step uses Rcon[7]=8'h40;
//    the n=1 step uses Rcon[1]=8'h01.
//  - Throughput: one round key per cycle while ready_i is held high.
//    A full walk takes 15 beats, plus 1 load cycle.
//  - Back-to-back: the earliest next key load is the cycle after the n=0 beat
//    (key_ready_o=1 in that cycle).
//  - Do not touch W when no beat occurs.
//  - Counter never wraps: n=0 is terminal, so round_o never shows 15.
// TESTING
//  1 FIPS-197 C.3 key 000102..1f: load its expanded rk13||rk14, ready_i=1.
//    First beat: round 14 rk_o=24fc79ccbf0979e9371ac23c6d68de36.
//    Second-to-last beat: round 1, 101112131415161718191a1b1c1d1e1f.
//    Last beat: round 0, 000102030405060708090a0b0c0d0e0f, last_o=1.
//    Exactly 15 beats in total.
//  2 FIPS-197 A.3 key 603deb10..0914dff4: all 15 rk_o match a forward-expansion
//    golden model in reverse order. Also check forward-then-inverse round-trip
//    on 100 random keys.
//  3 ready_i random 50% duty: rk_o/round_o stable while stalled; sequence
//    identical to scenario 1; key_v_i pulses during EMIT are ignored.
//  4 reset_n_i low at round_o=7 mid-walk: v_o=0 and key_ready_o=1 immediately.
//    Next load restarts cleanly at round 14.
//  5 Two keys back-to-back with key_v_i held high: second accepted the cycle
//    after the first walk's last beat; no beat dropped or duplicated.
//  6 After reset with no key loaded: v_o, rk_o, round_o, last_o all 0 for 20
//    cycles.

Source files
------------

// File: rtl/inv_round_key_seq.sv
// AES-256 inverse key-schedule walker: loads rk13||rk14 and emits rk14..rk0,
// one round key per handshake beat, regenerating four earlier words per step.
module inv_round_key_seq #(
  parameter int unsigned word_w_p     = 32,
  parameter int unsigned num_rounds_p = 14
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    key_v_i,
  output logic                    key_ready_o,
  input  logic [8*word_w_p-1:0]   key_i,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic [4*word_w_p-1:0]   rk_o,
  output logic [3:0]              round_o,
  output logic                    last_o
);

  localparam int unsigned WORDS = 8;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bits [8*(255-x)+7 -: 8] of the packed table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                state_q, state_d;
  logic [word_w_p-1:0]   w_q [WORDS];
  logic [word_w_p-1:0]   w_d [WORDS];
  logic [3:0]            n_q, n_d;
  logic                  v_q, v_d;
  logic                  key_ready_q, key_ready_d;
  logic                  last_q, last_d;
  logic [4*word_w_p-1:0] rk_q, rk_d;
  logic [3:0]            round_q, round_d;

  logic [word_w_p-1:0]   t_in_c, sub_c, t_c;
  logic [7:0]            rcon_c;
  logic                  beat_c;

  // T(W[3]): odd steps rotate and add Rcon[(n+1)/2], even steps only substitute.
  always_comb begin
    t_in_c = n_q[0] ? {w_q[3][23:0], w_q[3][31:24]} : w_q[3];
    sub_c  = {sbox(t_in_c[31:24]), sbox(t_in_c[23:16]),
              sbox(t_in_c[15:8]),  sbox(t_in_c[7:0])};
    rcon_c = n_q[0] ? 8'(8'h01 << n_q[3:1]) : 8'h00;
    t_c    = sub_c ^ {rcon_c, 24'h000000};
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    for (int i = 0; i < WORDS; i++) w_d[i] = w_q[i];
    beat_c  = (state_q == EMIT) && ready_i;

    case (state_q)
      IDLE: begin
        if (key_v_i) begin
          state_d = EMIT;
          n_d     = 4'(num_rounds_p);
          for (int i = 0; i < WORDS; i++) w_d[i] = key_i[(WORDS-1-i)*word_w_p +: word_w_p];
        end
      end
      EMIT: begin
        if (beat_c) begin
          if (n_q == 4'd0) begin
            state_d = IDLE;
          end else if (n_q == 4'(num_rounds_p)) begin
            n_d = n_q - 4'd1;
          end else begin
            w_d[0] = w_q[4] ^ t_c;
            w_d[1] = w_q[5] ^ w_q[4];
            w_d[2] = w_q[6] ^ w_q[5];
            w_d[3] = w_q[7] ^ w_q[6];
            for (int i = 0; i < 4; i++) w_d[i+4] = w_q[i];
            n_d = n_q - 4'd1;
          end
        end
      end
    endcase

    // Outputs are registered copies of what the next state will present.
    v_d         = (state_d == EMIT);
    key_ready_d = (state_d == IDLE);
    round_d     = n_d;
    last_d      = v_d && (n_d == 4'd0);
    rk_d        = (n_d == 4'(num_rounds_p)) ? {w_d[4], w_d[5], w_d[6], w_d[7]}
                                            : {w_d[0], w_d[1], w_d[2], w_d[3]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      n_q         <= 4'd0;
      for (int i = 0; i < WORDS; i++) w_q[i] <= '0;
      v_q         <= 1'b0;
      key_ready_q <= 1'b1;
      last_q      <= 1'b0;
      rk_q        <= '0;
      round_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      for (int i = 0; i < WORDS; i++) w_q[i] <= w_d[i];
      v_q         <= v_d;
      key_ready_q <= key_ready_d;
      last_q      <= last_d;
      rk_q        <= rk_d;
      round_q     <= round_d;
    end
  end

  assign v_o         = v_q;
  assign key_ready_o = key_ready_q;
  assign last_o      = last_q;
  assign rk_o        = rk_q;
  assign round_o     = round_q;

endmodule

// File: tb/tb_inv_round_key_seq.sv
// Scoreboard bench for inv_round_key_seq: a forward AES-256 expansion model
// predicts the reverse round-key sequence; a monitor pops and compares each beat.
module tb_inv_round_key_seq;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         key_v_i = 1'b0;
  logic         key_ready_o;
  logic [255:0] key_i = '0;
  logic         v_o;
  logic         ready_i = 1'b0;
  logic [127:0] rk_o;
  logic [3:0]   round_o;
  logic         last_o;

  always #5 clk_i = ~clk_i;

  inv_round_key_seq #(.word_w_p(32), .num_rounds_p(14)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .key_v_i(key_v_i), .key_ready_o(key_ready_o),
    .key_i(key_i), .v_o(v_o), .ready_i(ready_i), .rk_o(rk_o), .round_o(round_o),
    .last_o(last_o)
  );

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] JUNK   = 256'hdeadbeef_cafef00d_01234567_89abcdef_fedcba98_76543210_55aa55aa_a5a5a5a5;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] rk;
    logic         last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] fw [60];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beats = 0;
  int          last_beat_cyc = -100;
  int          r14_gap = 0;
  logic        prev_stall = 1'b0;
  logic [127:0] prev_rk;
  logic [3:0]  prev_rnd;

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Forward FIPS-197 key expansion for Nk=8, Nr=14.
  task automatic expand(input logic [255:0] k);
    logic [31:0] t;
    for (int i = 0; i < 8; i++) fw[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = fw[i-1];
      if (i % 8 == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {8'(8'h01 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4)
        t = sub_word(t);
      fw[i] = fw[i-8] ^ t;
    end
  endtask

  task automatic push_walk(input logic [255:0] k, input bit hand, output logic [255:0] ld);
    exp_t e;
    expand(k);
    ld = {fw[52], fw[53], fw[54], fw[55], fw[56], fw[57], fw[58], fw[59]};
    for (int n = 14; n >= 0; n--) begin
      e.rnd  = 4'(n);
      e.rk   = {fw[4*n], fw[4*n+1], fw[4*n+2], fw[4*n+3]};
      e.last = (n == 0);
      if (hand && n == 14) e.rk = 128'h24fc79ccbf0979e9371ac23c6d68de36;
      if (hand && n == 1)  e.rk = 128'h101112131415161718191a1b1c1d1e1f;
      if (hand && n == 0)  e.rk = 128'h000102030405060708090a0b0c0d0e0f;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [255:0] ld);
    int t = 0;
    while (!key_ready_o && t < 200) begin tick(); t++; end
    checks++;
    if (!key_ready_o) begin
      errors++;
      $display("FAIL load_wait: key_ready_o %b required 1", key_ready_o);
    end
    key_i = ld;
    key_v_i = 1'b1;
    tick();
    key_v_i = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: random ready with ignored key pulses.
  task automatic drain(input int mode);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      ready_i = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      if (mode == 1 && !key_ready_o) begin
        key_v_i = ($urandom_range(0, 2) == 0);
        key_i = JUNK;
      end else begin
        key_v_i = 1'b0;
      end
      tick();
      t++;
    end
    ready_i = 1'b0;
    key_v_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: hold-stability while stalled, and scoreboard comparison on every beat.
  always @(negedge clk_i) begin
    cyc++;
    if (!reset_n_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && v_o) begin
        checks++;
        if (rk_o !== prev_rk || round_o !== prev_rnd) begin
          errors++;
          $display("FAIL hold: rk %h round %0d required rk %h round %0d", rk_o, round_o, prev_rk, prev_rnd);
        end
      end
      prev_stall = v_o && !ready_i;
      prev_rk    = rk_o;
      prev_rnd   = round_o;
      if (v_o && ready_i) begin
        beats++;
        if (round_o == 4'd14) r14_gap = cyc - last_beat_cyc;
        if (last_o) last_beat_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: round %0d rk %h required no beat", round_o, rk_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (round_o !== mon_e.rnd || rk_o !== mon_e.rk || last_o !== mon_e.last) begin
            errors++;
            $display("FAIL beat: round %0d rk %h last %b required round %0d rk %h last %b",
                     round_o, rk_o, last_o, mon_e.rnd, mon_e.rk, mon_e.last);
          end
        end
      end
    end
  end

  initial begin
    logic [255:0] ld, ld_b, k;
    int b0, t;

    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (v_o !== 1'b0 || key_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: v %b ready %b required v 0 ready 1", v_o, key_ready_o);
    end
    reset_n_i = 1'b1;

    // Idle after reset with no key loaded.
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (v_o !== 1'b0 || rk_o !== '0 || round_o !== 4'd0 || last_o !== 1'b0 || key_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL idle: v %b rk %h round %0d last %b ready %b required 0 0 0 0 1",
                 v_o, rk_o, round_o, last_o, key_ready_o);
      end
    end

    // FIPS-197 C.3 key, ready held high, exactly 15 beats.
    b0 = beats;
    push_walk(KEY_C3, 1'b1, ld);
    load(ld);
    drain(0);
    repeat (5) tick();
    checks++;
    if (beats - b0 != 15) begin
      errors++;
      $display("FAIL beat_count: %0d required 15", beats - b0);
    end

    // FIPS-197 A.3 key, then forward-then-inverse round trip on random keys.
    push_walk(KEY_A3, 1'b0, ld);
    load(ld);
    drain(0);
    for (int r = 0; r < 100; r++) begin
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
      push_walk(k, 1'b0, ld);
      load(ld);
      drain(0);
    end

    // Random stalls with ignored key pulses; same sequence as the C.3 walk.
    push_walk(KEY_C3, 1'b1, ld);
    load(ld);
    drain(1);

    // Reset mid-walk at round 7, then a clean restart.
    push_walk(KEY_C3, 1'b1, ld);
    load(ld);
    ready_i = 1'b1;
    t = 0;
    while (!(v_o && round_o == 4'd7) && t < 50) begin tick(); t++; end
    checks++;
    if (!(v_o && round_o == 4'd7)) begin
      errors++;
      $display("FAIL reach_round7: round %0d v %b required round 7 v 1", round_o, v_o);
    end
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0 || key_ready_o !== 1'b1 || round_o !== 4'd0 || last_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: v %b ready %b round %0d last %b required 0 1 0 0",
               v_o, key_ready_o, round_o, last_o);
    end
    exp_q.delete();
    ready_i = 1'b0;
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
    push_walk(KEY_C3, 1'b1, ld);
    load(ld);
    drain(0);

    // Back-to-back keys with key_v_i held high throughout.
    push_walk(KEY_A3, 1'b0, ld);
    push_walk(KEY_C3, 1'b1, ld_b);
    key_i = ld;
    key_v_i = 1'b1;
    ready_i = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!v_o && t < 20);
    key_i = ld_b;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin tick(); t++; end
    key_v_i = 1'b0;
    ready_i = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: pending %0d required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (r14_gap != 2) begin
      errors++;
      $display("FAIL b2b_gap: %0d cycles required 2", r14_gap);
    end
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
